tl_rx_vc_wr_ctrl: RTL and testbench

//  Write-side controller directly upstream of the RX VC buffers (P / NP / CPL). Accepts decoded TLP

---
 rtl/tl_rx_vc_wr_ctrl.sv | 164 ++++++++++++++++
 tb/tb_tl_rx_vc_wr_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rx_vc_wr_ctrl.sv
// RX VC buffer write controller: steers TLP beats to P/NP/CPL buffers, drops invalid types (stats: TL_RX_WR_STATS_EN).
// Latency: 1 cycle from accepted beat to buffer write strobes; o_tlp_ready is combinational.
// Backpressure: ready follows the selected buffer's hdr/data full flags; dropped TLPs are always accepted.
module tl_rx_vc_wr_ctrl #(
  parameter int DW               = 32,
  parameter int W_CTRL_BUS_WIDTH = 5,
  parameter int FLAGS_WIDTH      = 6
) (
  input  logic                        i_clk,
  input  logic                        i_n_rst,
  input  logic                        i_tlp_valid,
  output logic                        o_tlp_ready,
  input  logic                        i_tlp_sop,
  input  logic                        i_tlp_eop,
  input  logic [1:0]                  i_tlp_type,
  input  logic [4*DW-1:0]             i_tlp_hdr,
  input  logic [8*DW-1:0]             i_tlp_data,
  input  logic [3:0]                  i_tlp_dw_cnt,
  input  logic [FLAGS_WIDTH-1:0]      i_vc_w_full_flags,
  output logic [W_CTRL_BUS_WIDTH-1:0] o_w_posted_ctrl,
  output logic [W_CTRL_BUS_WIDTH-1:0] o_w_non_posted_ctrl,
  output logic [W_CTRL_BUS_WIDTH-1:0] o_w_completion_ctrl,
  output logic [4*DW-1:0]             o_w_posted_hdr,
  output logic [4*DW-1:0]             o_w_non_posted_hdr,
  output logic [4*DW-1:0]             o_w_completion_hdr,
  output logic [8*DW-1:0]             o_w_posted_data,
  output logic [8*DW-1:0]             o_w_non_posted_data,
  output logic [8*DW-1:0]             o_w_completion_data,
  output logic                        o_proto_err,
  output logic [7:0]                  o_drop_cnt,
  output logic [15:0]                 o_p_tlp_cnt,
  output logic [15:0]                 o_np_tlp_cnt,
  output logic [15:0]                 o_cpl_tlp_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  localparam logic [1:0] T_INV = 2'b11;

  state_t     state;
  logic [1:0] cur_type;

  logic [W_CTRL_BUS_WIDTH-1:0] ctrl_q [3];
  logic [4*DW-1:0]             hdr_q  [3];
  logic [8*DW-1:0]             data_q [3];

  logic [3:0] dw_eff;
  logic [2:0] dw_m1;
  logic       has_data;
  logic [1:0] sel_type;
  logic       hdr_full_sel;
  logic       data_full_sel;
  logic       ready_c;
  logic       accept;
  logic       wr_en;
  logic       wr_hdr;
  logic       start_pkt;

  assign dw_eff   = (i_tlp_dw_cnt > 4'd8) ? 4'd8 : i_tlp_dw_cnt;
  assign has_data = (dw_eff != 4'd0);
  assign dw_m1    = has_data ? 3'(dw_eff - 4'd1) : 3'd0;
  assign sel_type = (state == IDLE) ? i_tlp_type : cur_type;

  // Flag vector is {p_hdr, p_data, np_hdr, np_data, cpl_hdr, cpl_data}.
  always_comb begin
    hdr_full_sel  = 1'b0;
    data_full_sel = 1'b0;
    case (sel_type)
      2'b00: begin hdr_full_sel = i_vc_w_full_flags[5]; data_full_sel = i_vc_w_full_flags[4]; end
      2'b01: begin hdr_full_sel = i_vc_w_full_flags[3]; data_full_sel = i_vc_w_full_flags[2]; end
      2'b10: begin hdr_full_sel = i_vc_w_full_flags[1]; data_full_sel = i_vc_w_full_flags[0]; end
      default: ;
    endcase
  end

  always_comb begin
    ready_c = 1'b1;
    case (state)
      IDLE: if (i_tlp_sop && i_tlp_type != T_INV)
              ready_c = !hdr_full_sel && (!has_data || !data_full_sel);
      DATA: ready_c = !has_data || !data_full_sel;
      default: ready_c = 1'b1;
    endcase
  end

  assign o_tlp_ready = i_n_rst && ready_c;
  assign accept      = i_tlp_valid && o_tlp_ready;
  assign start_pkt   = accept && (state == IDLE) && i_tlp_sop;
  assign wr_hdr      = start_pkt && (i_tlp_type != T_INV);
  assign wr_en       = wr_hdr || (accept && state == DATA);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state       <= IDLE;
      cur_type    <= 2'b00;
      o_proto_err <= 1'b0;
      o_drop_cnt  <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        ctrl_q[i] <= '0;
        hdr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      o_proto_err <= accept && ((i_tlp_dw_cnt > 4'd8) ||
                                (i_tlp_sop && state != IDLE) ||
                                (!i_tlp_sop && state == IDLE));
      for (int i = 0; i < 3; i++) begin
        ctrl_q[i] <= '0;
        if (wr_en && sel_type == 2'(i)) begin
          ctrl_q[i] <= W_CTRL_BUS_WIDTH'({dw_m1, has_data, wr_hdr});
          if (wr_hdr)   hdr_q[i]  <= i_tlp_hdr;
          if (has_data) data_q[i] <= i_tlp_data;
        end
      end
      if (start_pkt && i_tlp_type == T_INV && o_drop_cnt != 8'hFF)
        o_drop_cnt <= o_drop_cnt + 8'd1;
      if (start_pkt) begin
        cur_type <= i_tlp_type;
        if (!i_tlp_eop)
          state <= (i_tlp_type == T_INV) ? DROP : DATA;
      end else if (accept && state != IDLE && i_tlp_eop) begin
        state <= IDLE;
      end
    end
  end

  assign o_w_posted_ctrl     = ctrl_q[0];
  assign o_w_non_posted_ctrl = ctrl_q[1];
  assign o_w_completion_ctrl = ctrl_q[2];
  assign o_w_posted_hdr      = hdr_q[0];
  assign o_w_non_posted_hdr  = hdr_q[1];
  assign o_w_completion_hdr  = hdr_q[2];
  assign o_w_posted_data     = data_q[0];
  assign o_w_non_posted_data = data_q[1];
  assign o_w_completion_data = data_q[2];

`ifdef TL_RX_WR_STATS_EN
  logic [15:0] p_cnt, np_cnt, cpl_cnt;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      p_cnt   <= 16'd0;
      np_cnt  <= 16'd0;
      cpl_cnt <= 16'd0;
    end else if (wr_hdr) begin
      case (i_tlp_type)
        2'b00:   p_cnt   <= p_cnt + 16'd1;
        2'b01:   np_cnt  <= np_cnt + 16'd1;
        2'b10:   cpl_cnt <= cpl_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_p_tlp_cnt   = p_cnt;
  assign o_np_tlp_cnt  = np_cnt;
  assign o_cpl_tlp_cnt = cpl_cnt;
`else
  assign o_p_tlp_cnt   = 16'd0;
  assign o_np_tlp_cnt  = 16'd0;
  assign o_cpl_tlp_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_tl_rx_vc_wr_ctrl.sv
// Bench for tl_rx_vc_wr_ctrl: packet-level model checked every cycle plus directed literal pins.
module tb_tl_rx_vc_wr_ctrl;
  localparam int DW = 32;

  logic           i_clk = 1'b0;
  logic           i_n_rst;
  logic           i_tlp_valid, i_tlp_sop, i_tlp_eop;
  logic [1:0]     i_tlp_type;
  logic [4*DW-1:0] i_tlp_hdr;
  logic [8*DW-1:0] i_tlp_data;
  logic [3:0]     i_tlp_dw_cnt;
  logic [5:0]     i_vc_w_full_flags;
  logic           o_tlp_ready, o_proto_err;
  logic [4:0]     o_w_posted_ctrl, o_w_non_posted_ctrl, o_w_completion_ctrl;
  logic [4*DW-1:0] o_w_posted_hdr, o_w_non_posted_hdr, o_w_completion_hdr;
  logic [8*DW-1:0] o_w_posted_data, o_w_non_posted_data, o_w_completion_data;
  logic [7:0]     o_drop_cnt;
  logic [15:0]    o_p_tlp_cnt, o_np_tlp_cnt, o_cpl_tlp_cnt;

  tl_rx_vc_wr_ctrl dut (
    .i_clk(i_clk), .i_n_rst(i_n_rst), .i_tlp_valid(i_tlp_valid), .o_tlp_ready(o_tlp_ready),
    .i_tlp_sop(i_tlp_sop), .i_tlp_eop(i_tlp_eop), .i_tlp_type(i_tlp_type),
    .i_tlp_hdr(i_tlp_hdr), .i_tlp_data(i_tlp_data), .i_tlp_dw_cnt(i_tlp_dw_cnt),
    .i_vc_w_full_flags(i_vc_w_full_flags),
    .o_w_posted_ctrl(o_w_posted_ctrl), .o_w_non_posted_ctrl(o_w_non_posted_ctrl),
    .o_w_completion_ctrl(o_w_completion_ctrl),
    .o_w_posted_hdr(o_w_posted_hdr), .o_w_non_posted_hdr(o_w_non_posted_hdr),
    .o_w_completion_hdr(o_w_completion_hdr),
    .o_w_posted_data(o_w_posted_data), .o_w_non_posted_data(o_w_non_posted_data),
    .o_w_completion_data(o_w_completion_data),
    .o_proto_err(o_proto_err), .o_drop_cnt(o_drop_cnt),
    .o_p_tlp_cnt(o_p_tlp_cnt), .o_np_tlp_cnt(o_np_tlp_cnt), .o_cpl_tlp_cnt(o_cpl_tlp_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: packet-level view of what each buffer must see after the next edge.
  logic [4:0]      e_ctrl [3];
  logic [4*DW-1:0] e_hdr  [3];
  logic [8*DW-1:0] e_data [3];
  logic            e_perr;
  int              e_drop;
  int              e_cnt  [3];
  bit              in_pkt, pkt_drop;
  int              pkt_type;

  function automatic bit hfull(int t); return i_vc_w_full_flags[5-2*t]; endfunction
  function automatic bit dfull(int t); return i_vc_w_full_flags[4-2*t]; endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      e_ctrl[i] = 0; e_hdr[i] = 0; e_data[i] = 0; e_cnt[i] = 0;
    end
    e_perr = 0; e_drop = 0; in_pkt = 0; pkt_drop = 0; pkt_type = 0;
  endtask

  task automatic model_write(int t, bit h, int dw);
    e_ctrl[t] = {(dw > 0) ? 3'(dw - 1) : 3'd0, dw > 0, h};
    if (h) e_hdr[t] = i_tlp_hdr;
    if (dw > 0) e_data[t] = i_tlp_data;
  endtask

  initial model_reset();

  always @(negedge i_clk) begin
    if (!i_n_rst) begin
      model_reset();
      chk("rst_ready", 256'(o_tlp_ready), 0);
      chk("rst_ctrl", 256'({o_w_posted_ctrl, o_w_non_posted_ctrl, o_w_completion_ctrl}), 0);
    end else begin
      int  dw, typ;
      bit  r, acc;
      chk("m_p_ctrl",   256'(o_w_posted_ctrl),     256'(e_ctrl[0]));
      chk("m_np_ctrl",  256'(o_w_non_posted_ctrl), 256'(e_ctrl[1]));
      chk("m_cpl_ctrl", 256'(o_w_completion_ctrl), 256'(e_ctrl[2]));
      chk("m_p_hdr",    256'(o_w_posted_hdr),      256'(e_hdr[0]));
      chk("m_np_hdr",   256'(o_w_non_posted_hdr),  256'(e_hdr[1]));
      chk("m_cpl_hdr",  256'(o_w_completion_hdr),  256'(e_hdr[2]));
      chk("m_p_data",   o_w_posted_data,           e_data[0]);
      chk("m_np_data",  o_w_non_posted_data,       e_data[1]);
      chk("m_cpl_data", o_w_completion_data,       e_data[2]);
      chk("m_perr",     256'(o_proto_err),         256'(e_perr));
      chk("m_drop",     256'(o_drop_cnt),          256'(e_drop));
`ifdef TL_RX_WR_STATS_EN
      chk("m_pcnt",   256'(o_p_tlp_cnt),   256'(e_cnt[0] % 65536));
      chk("m_npcnt",  256'(o_np_tlp_cnt),  256'(e_cnt[1] % 65536));
      chk("m_cplcnt", 256'(o_cpl_tlp_cnt), 256'(e_cnt[2] % 65536));
`else
      chk("m_cnt0", 256'({o_p_tlp_cnt, o_np_tlp_cnt, o_cpl_tlp_cnt}), 0);
`endif
      dw  = (i_tlp_dw_cnt > 8) ? 8 : int'(i_tlp_dw_cnt);
      typ = int'(i_tlp_type);
      if (!in_pkt) r = (!i_tlp_sop || typ == 3) ? 1 : (!hfull(typ) && (dw == 0 || !dfull(typ)));
      else if (pkt_drop) r = 1;
      else r = (dw == 0) || !dfull(pkt_type);
      chk("m_ready", 256'(o_tlp_ready), 256'(r));
      acc = i_tlp_valid && r;
      for (int i = 0; i < 3; i++) e_ctrl[i] = 0;
      e_perr = acc && (i_tlp_dw_cnt > 8 || (i_tlp_sop && in_pkt) || (!i_tlp_sop && !in_pkt));
      if (acc) begin
        if (!in_pkt) begin
          if (i_tlp_sop) begin
            if (typ == 3) begin
              if (e_drop < 255) e_drop++;
            end else begin
              model_write(typ, 1, dw);
              e_cnt[typ]++;
            end
            if (!i_tlp_eop) begin in_pkt = 1; pkt_drop = (typ == 3); pkt_type = typ; end
          end
        end else begin
          if (!pkt_drop) model_write(pkt_type, 0, dw);
          if (i_tlp_eop) in_pkt = 0;
        end
      end
    end
  end

  // Drive one beat and hold it until accepted; returns cycles spent.
  task automatic send(input bit sop, input bit eop, input logic [1:0] t,
                      input logic [3:0] dw, input int s, output int n);
    bit acc;
    i_tlp_valid = 1; i_tlp_sop = sop; i_tlp_eop = eop; i_tlp_type = t; i_tlp_dw_cnt = dw;
    i_tlp_hdr = {32'(s), 32'(s + 1), 32'hC0DE0000 | 32'(s), ~32'(s)};
    for (int i = 0; i < 8; i++) i_tlp_data[i*32 +: 32] = 32'(s * 16 + i) ^ 32'h5A5A0000;
    n = 0;
    do begin
      @(negedge i_clk); acc = o_tlp_ready;
      @(posedge i_clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    i_tlp_valid = 0;
  endtask

  int n;
  logic [4*DW-1:0] h_ref;

  initial begin
    i_n_rst = 0; i_tlp_valid = 0; i_tlp_sop = 0; i_tlp_eop = 0; i_tlp_type = 0;
    i_tlp_hdr = 0; i_tlp_data = 0; i_tlp_dw_cnt = 0; i_vc_w_full_flags = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", 256'(o_tlp_ready), 0);
    chk("reset_outs", 256'({o_w_posted_ctrl, o_w_non_posted_ctrl, o_w_completion_ctrl,
                            o_proto_err, o_drop_cnt}), 0);
    i_n_rst = 1;
    @(posedge i_clk); #1;

    // P MWr single beat
    send(1, 1, 2'b00, 4'd4, 10, n);
    chk("t1_p_ctrl", 256'(o_w_posted_ctrl), 256'(5'b01111));
    h_ref = {32'd10, 32'd11, 32'hC0DE000A, ~32'd10};
    chk("t1_p_hdr", 256'(o_w_posted_hdr), 256'(h_ref));
    chk("t1_other", 256'({o_w_non_posted_ctrl, o_w_completion_ctrl}), 0);

    // CPL: header beat then 8, 8, 2 DWs, no stalls
    send(1, 0, 2'b10, 4'd0, 20, n); chk("t2_hdr", 256'(o_w_completion_ctrl), 256'(5'b00001));
    send(0, 0, 2'b10, 4'd8, 21, n); chk("t2_b1", 256'(o_w_completion_ctrl), 256'(5'b11110));
    chk("t2_nostall", n, 1);
    send(0, 0, 2'b10, 4'd8, 22, n); chk("t2_b2", 256'(o_w_completion_ctrl), 256'(5'b11110));
    send(0, 1, 2'b10, 4'd2, 23, n); chk("t2_b3", 256'(o_w_completion_ctrl), 256'(5'b00110));

    // NP header full holds the SOP
    i_vc_w_full_flags = 6'b001000;
    i_tlp_valid = 1; i_tlp_sop = 1; i_tlp_eop = 1; i_tlp_type = 2'b01; i_tlp_dw_cnt = 4'd1;
    repeat (3) begin
      @(negedge i_clk);
      chk("t3_ready0", 256'(o_tlp_ready), 0);
      chk("t3_nowr", 256'(o_w_non_posted_ctrl), 0);
    end
    @(posedge i_clk); #1;
    i_vc_w_full_flags = 6'b000000;
    send(1, 1, 2'b01, 4'd1, 30, n);
    chk("t3_np_hdrwe", 256'(o_w_non_posted_ctrl[0]), 1);

    // P data full mid-packet, released after a few cycles
    send(1, 0, 2'b00, 4'd0, 40, n);
    i_vc_w_full_flags = 6'b010000;
    send(0, 0, 2'b00, 4'd0, 41, n); chk("bp_zero_dw_passes", n, 1);
    fork begin repeat (3) @(posedge i_clk); #2; i_vc_w_full_flags = 0; end join_none
    send(0, 1, 2'b00, 4'd3, 42, n); chk("bp_stalled", 256'(n > 1), 1);
    chk("bp_p_ctrl", 256'(o_w_posted_ctrl), 256'(5'b01010));

    // Invalid type: two beats dropped, then saturate
    send(1, 0, 2'b11, 4'd2, 50, n); chk("t4_drop1", 256'(o_drop_cnt), 1);
    send(0, 1, 2'b11, 4'd2, 51, n);
    chk("t4_noctrl", 256'({o_w_posted_ctrl, o_w_non_posted_ctrl, o_w_completion_ctrl}), 0);
    for (int i = 0; i < 256; i++) send(1, 1, 2'b11, 4'd0, 60 + i, n);
    chk("t4_sat", 256'(o_drop_cnt), 255);

    // Framing errors
    send(1, 0, 2'b00, 4'd2, 70, n);
    send(1, 0, 2'b00, 4'd1, 71, n);
    chk("t5_sop_in_data_err", 256'(o_proto_err), 1);
    chk("t5_sop_in_data_ctrl", 256'(o_w_posted_ctrl), 256'(5'b00010));
    send(0, 1, 2'b00, 4'd0, 72, n);
    chk("t5_err_one_pulse", 256'(o_proto_err), 0);
    send(0, 1, 2'b01, 4'd3, 73, n);
    chk("t5_idle_nonsop_err", 256'(o_proto_err), 1);
    chk("t5_idle_nonsop_nowr", 256'({o_w_posted_ctrl, o_w_non_posted_ctrl, o_w_completion_ctrl}), 0);
    send(1, 1, 2'b00, 4'd12, 74, n);
    chk("t5_dw_clamp_ctrl", 256'(o_w_posted_ctrl), 256'(5'b11111));
    chk("t5_dw_clamp_err", 256'(o_proto_err), 1);

    // Reset mid-packet
    send(1, 0, 2'b01, 4'd3, 80, n);
    i_n_rst = 0; #1;
    chk("t5_rst_outs", 256'({o_w_non_posted_ctrl, o_drop_cnt}), 0);
    chk("t5_rst_hdr", 256'(o_w_non_posted_hdr), 0);
    @(posedge i_clk); #1; i_n_rst = 1;
    send(0, 1, 2'b01, 4'd2, 81, n);
    chk("t5_post_rst_err", 256'(o_proto_err), 1);
    chk("t5_post_rst_nowr", 256'(o_w_non_posted_ctrl), 0);

`ifdef TL_RX_WR_STATS_EN
    send(1, 1, 2'b00, 4'd0, 90, n);
    chk("t6_p_one", 256'(o_p_tlp_cnt), 1);
    for (int i = 0; i < 65535; i++) send(1, 1, 2'b00, 4'd0, i, n);
    chk("t6_p_wrap", 256'(o_p_tlp_cnt), 0);
`else
    chk("t6_cnt_tied", 256'({o_p_tlp_cnt, o_np_tlp_cnt, o_cpl_tlp_cnt}), 0);
`endif

    repeat (2) @(posedge i_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
